// File: rtl/midi_pkg.sv
// midi_pkg: shared definitions for the MIDI receive front end.
//   - status-nibble constants for channel-voice and system messages
//   - receiver and parser state encodings
//   - midi_event_t: one note event (on flag, note number, velocity)
package midi_pkg;

    localparam logic [3:0] NOTE_OFF   = 4'h8;
    localparam logic [3:0] NOTE_ON    = 4'h9;
    localparam logic [3:0] POLY_AT    = 4'hA;
    localparam logic [3:0] CTRL_CHG   = 4'hB;
    localparam logic [3:0] PROG_CHG   = 4'hC;
    localparam logic [3:0] CHAN_AT    = 4'hD;
    localparam logic [3:0] PITCH_BEND = 4'hE;
    localparam logic [3:0] SYS        = 4'hF;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        P_IDLE,
        P_WAIT_D1,
        P_WAIT_D2,
        P_SKIP1,
        P_SKIP2
    } parse_state_t;

    typedef struct packed {
        logic       on;
        logic [6:0] note;
        logic [6:0] velocity;
    } midi_event_t;

endpackage

// File: rtl/midi_uart_rx.sv
// midi_uart_rx: 8N1 serial receiver for the MIDI line.
//   clk_i       - system clock, rising edge
//   nrst_i      - asynchronous active-low reset
//   rxData_i    - asynchronous serial input, idle high
//   byte_o      - last received byte, valid with byteValid_o
//   byteValid_o - one-cycle strobe for a correctly framed byte
//   frameErr_o  - one-cycle strobe when the stop bit samples low
// Start is detected on a falling edge of the synchronised line, so a line
// held low after a frame (break) never retriggers reception.
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 320
) (
    input  logic       clk_i,
    input  logic       nrst_i,
    input  logic       rxData_i,
    output logic [7:0] byte_o,
    output logic       byteValid_o,
    output logic       frameErr_o
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic          sync1, sync2, sync_prev;
    rx_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          valid_n, ferr_n;
    logic          fall;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync1     <= rxData_i;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    assign fall = sync_prev & ~sync2;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state       <= RX_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            byteValid_o <= 1'b0;
            frameErr_o  <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bit_idx     <= bit_idx_n;
            shreg       <= shreg_n;
            byteValid_o <= valid_n;
            frameErr_o  <= ferr_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_n = '0;
                if (fall) state_n = RX_START;
            end
            RX_START: begin
                // Mid-start sample: a high line means the low pulse was a glitch.
                if (cnt == HALF_LAST) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = sync2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_n   = '0;
                    shreg_n = {sync2, shreg[7:1]};
                    if (bit_idx == 3'd7) state_n = RX_STOP;
                    else bit_idx_n = bit_idx + 3'd1;
                end
            end
            RX_STOP: begin
                if (cnt == FULL_LAST) begin
                    cnt_n   = '0;
                    state_n = RX_IDLE;
                    valid_n = sync2;
                    ferr_n  = ~sync2;
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

    assign byte_o = shreg;

endmodule

// File: rtl/midi_rx.sv
// midi_rx: MIDI input front end producing note-on/note-off events.
//   clk_i       - system clock, rising edge
//   nrst_i      - asynchronous active-low reset
//   rxData_i    - asynchronous MIDI serial line, idle high
//   noteValid_o - one-cycle event strobe
//   noteOn_o    - 1 = note-on, 0 = note-off (note-on velocity 0 reads as off)
//   noteNum_o   - note number, held until the next event
//   velocity_o  - velocity, held until the next event
//   frameErr_o  - one-cycle strobe on a low stop bit
// The parser tracks running status for note messages and skips other
// channel-voice messages with their own running status.
module midi_rx
    import midi_pkg::*;
#(
    parameter int CLK_FREQ = 10_000_000,
    parameter int BAUD     = 31250,
    parameter int MIDI_CH  = 0,
    parameter int OMNI     = 1
) (
    input  logic       clk_i,
    input  logic       nrst_i,
    input  logic       rxData_i,
    output logic       noteValid_o,
    output logic       noteOn_o,
    output logic [6:0] noteNum_o,
    output logic [6:0] velocity_o,
    output logic       frameErr_o
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;

    logic [7:0]   rx_byte;
    logic         rx_valid;

    parse_state_t ps, ps_n;
    logic         rs_on, rs_on_n;
    logic         skip_half, skip_half_n;
    logic [6:0]   note_q, note_n;
    midi_event_t  ev_q, ev_n;
    logic         ev_valid_q, ev_valid_n;
    logic         ch_ok;

    midi_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk_i      (clk_i),
        .nrst_i     (nrst_i),
        .rxData_i   (rxData_i),
        .byte_o     (rx_byte),
        .byteValid_o(rx_valid),
        .frameErr_o (frameErr_o)
    );

    assign ch_ok = (OMNI != 0) || (rx_byte[3:0] == 4'(MIDI_CH));

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            ps         <= P_IDLE;
            rs_on      <= 1'b0;
            skip_half  <= 1'b0;
            note_q     <= '0;
            ev_q       <= '0;
            ev_valid_q <= 1'b0;
        end else begin
            ps         <= ps_n;
            rs_on      <= rs_on_n;
            skip_half  <= skip_half_n;
            note_q     <= note_n;
            ev_q       <= ev_n;
            ev_valid_q <= ev_valid_n;
        end
    end

    always_comb begin
        ps_n        = ps;
        rs_on_n     = rs_on;
        skip_half_n = skip_half;
        note_n      = note_q;
        ev_n        = ev_q;
        ev_valid_n  = 1'b0;
        if (rx_valid) begin
            if (rx_byte[7:3] == 5'b11111) begin
                // Real-time bytes pass through without touching parser state.
            end else if (rx_byte[7:4] == SYS) begin
                ps_n    = P_IDLE;
                rs_on_n = 1'b0;
            end else if (rx_byte[7]) begin
                skip_half_n = 1'b0;
                case (rx_byte[7:4])
                    NOTE_OFF, NOTE_ON: begin
                        if (ch_ok) begin
                            ps_n    = P_WAIT_D1;
                            rs_on_n = (rx_byte[7:4] == NOTE_ON);
                        end else begin
                            ps_n = P_SKIP2;
                        end
                    end
                    POLY_AT, CTRL_CHG, PITCH_BEND: ps_n = P_SKIP2;
                    PROG_CHG, CHAN_AT:             ps_n = P_SKIP1;
                    default:                       ps_n = P_IDLE;
                endcase
            end else begin
                case (ps)
                    P_WAIT_D1: begin
                        note_n = rx_byte[6:0];
                        ps_n   = P_WAIT_D2;
                    end
                    P_WAIT_D2: begin
                        ev_valid_n = 1'b1;
                        ev_n.on       = rs_on & (|rx_byte[6:0]);
                        ev_n.note     = note_q;
                        ev_n.velocity = rx_byte[6:0];
                        ps_n          = P_WAIT_D1;
                    end
                    // Two-byte skip uses skip_half to pair data bytes while
                    // staying in SKIP2 for running status.
                    P_SKIP2: skip_half_n = ~skip_half;
                    default: ;
                endcase
            end
        end
    end

    assign noteValid_o = ev_valid_q;
    assign noteOn_o    = ev_q.on;
    assign noteNum_o   = ev_q.note;
    assign velocity_o  = ev_q.velocity;

endmodule

// File: tb/tb_midi_rx.sv
module tb_midi_rx;

    localparam int unsigned BIT = 320;

    logic       clk = 1'b0;
    logic       nrst;
    logic       rx, rx_ch;
    logic       v, on, v_c, on_c, fe, fe_c;
    logic [6:0] nn, vel, nn_c, vel_c;

    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned ev_cnt = 0, ev_ch_cnt = 0, fe_cnt = 0, byte_cnt = 0;
    int unsigned last_ev_cyc = 0;
    logic [14:0] exp_q[$];
    logic [14:0] exp_ch_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    midi_rx dut (
        .clk_i(clk), .nrst_i(nrst), .rxData_i(rx),
        .noteValid_o(v), .noteOn_o(on), .noteNum_o(nn),
        .velocity_o(vel), .frameErr_o(fe)
    );

    midi_rx #(.MIDI_CH(0), .OMNI(0)) dut_ch (
        .clk_i(clk), .nrst_i(nrst), .rxData_i(rx_ch),
        .noteValid_o(v_c), .noteOn_o(on_c), .noteNum_o(nn_c),
        .velocity_o(vel_c), .frameErr_o(fe_c)
    );

    function automatic logic [14:0] ev(input logic o, input logic [6:0] n, input logic [6:0] vv);
        return {o, n, vv};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // Scoreboard pops on every strobe of the omni instance.
    always @(negedge clk) begin
        if (fe) fe_cnt++;
        if (dut.u_uart.byteValid_o) byte_cnt++;
        if (v) begin
            logic [14:0] got, e;
            got = {on, nn, vel};
            ev_cnt++;
            last_ev_cyc = cyc;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL omni_unexpected_event: got %h expected none", got);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                assert (got === e) else begin
                    errors++;
                    $error("FAIL omni_event: got %h expected %h", got, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (v_c) begin
            logic [14:0] got, e;
            got = {on_c, nn_c, vel_c};
            ev_ch_cnt++;
            checks++;
            assert (exp_ch_q.size() != 0) else begin
                errors++;
                $error("FAIL ch_unexpected_event: got %h expected none", got);
            end
            if (exp_ch_q.size() != 0) begin
                e = exp_ch_q.pop_front();
                checks++;
                assert (got === e) else begin
                    errors++;
                    $error("FAIL ch_event: got %h expected %h", got, e);
                end
            end
        end
    end

    task automatic drive(input bit ch, input logic val);
        if (ch) rx_ch = val;
        else rx = val;
    endtask

    task automatic send_byte(input bit ch, input logic [7:0] b, input logic stop_bit,
                             output int unsigned start_cyc);
        start_cyc = cyc;
        drive(ch, 1'b0);
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drive(ch, b[i]);
            repeat (BIT) @(negedge clk);
        end
        drive(ch, stop_bit);
        repeat (BIT) @(negedge clk);
        drive(ch, 1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic send_seq(input bit ch, input logic [7:0] bytes[$]);
        int unsigned s;
        foreach (bytes[i]) send_byte(ch, bytes[i], 1'b1, s);
    endtask

    initial begin
        int unsigned s, e0, f0, b0;
        nrst = 1'b0; rx = 1'b1; rx_ch = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_valid",  {31'd0, v},    32'd0);
        chk("rst_on",     {31'd0, on},   32'd0);
        chk("rst_note",   {25'd0, nn},   32'd0);
        chk("rst_vel",    {25'd0, vel},  32'd0);
        chk("rst_ferr",   {31'd0, fe},   32'd0);
        chk("rst_valid_ch", {31'd0, v_c}, 32'd0);
        nrst = 1'b1;
        repeat (10) @(negedge clk);

        fork
            begin
                // Note-on with latency check on the third frame.
                exp_q.push_back(ev(1'b1, 7'd60, 7'd100));
                send_byte(0, 8'h90, 1'b1, s);
                send_byte(0, 8'h3C, 1'b1, s);
                send_byte(0, 8'h64, 1'b1, s);
                chk("noteon_count", ev_cnt, 32'd1);
                chk("noteon_latency", last_ev_cyc - s, 32'd3044);

                // Bad stop bit: one error strobe, no byte, parser unchanged.
                f0 = fe_cnt; b0 = byte_cnt;
                send_byte(0, 8'h3C, 1'b0, s);
                chk("ferr_count", fe_cnt - f0, 32'd1);
                chk("ferr_no_byte", byte_cnt - b0, 32'd0);

                // 100-cycle low glitch: no byte, no error.
                f0 = fe_cnt; b0 = byte_cnt;
                rx = 1'b0; repeat (100) @(negedge clk);
                rx = 1'b1; repeat (400) @(negedge clk);
                chk("glitch_no_byte", byte_cnt - b0, 32'd0);
                chk("glitch_no_ferr", fe_cnt - f0, 32'd0);

                e0 = ev_cnt;
                exp_q.push_back(ev(1'b1, 7'd60, 7'd100));
                send_seq(0, '{8'h3C, 8'h64});
                chk("after_err_count", ev_cnt - e0, 32'd1);

                e0 = ev_cnt;
                exp_q.push_back(ev(1'b1, 7'd60, 7'd100));
                exp_q.push_back(ev(1'b0, 7'd64, 7'd0));
                send_seq(0, '{8'h90, 8'h3C, 8'h64, 8'h40, 8'h00});
                chk("running_count", ev_cnt - e0, 32'd2);

                e0 = ev_cnt;
                exp_q.push_back(ev(1'b0, 7'd60, 7'd64));
                send_seq(0, '{8'h80, 8'hF8, 8'h3C, 8'hFE, 8'h40});
                chk("realtime_count", ev_cnt - e0, 32'd1);
            end
            begin
                send_seq(1, '{8'h91, 8'h3C, 8'h64, 8'hC0, 8'h05, 8'h06,
                              8'hB0, 8'h07, 8'h7F, 8'h01, 8'h02});
                chk("chan_filter_none", ev_ch_cnt, 32'd0);
                exp_ch_q.push_back(ev(1'b1, 7'd60, 7'd100));
                send_seq(1, '{8'h90, 8'h3C, 8'h64});
                chk("chan_accept_count", ev_ch_cnt, 32'd1);
            end
        join
        chk("omni_queue_empty", exp_q.size(), 32'd0);
        chk("ch_queue_empty", exp_ch_q.size(), 32'd0);

        // Reset in the middle of data bit 4 of a 0x90 frame.
        rx = 1'b0; repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = (i == 3) ? 1'b0 : 1'b0;
            repeat (BIT) @(negedge clk);
        end
        rx = 1'b1;
        repeat (BIT / 2) @(negedge clk);
        #1 nrst = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, v},   32'd0);
        chk("midrst_on",    {31'd0, on},  32'd0);
        chk("midrst_note",  {25'd0, nn},  32'd0);
        chk("midrst_vel",   {25'd0, vel}, 32'd0);
        chk("midrst_ferr",  {31'd0, fe},  32'd0);
        chk("midrst_note_ch", {25'd0, nn_c}, 32'd0);
        repeat (10) @(negedge clk);
        nrst = 1'b1;
        repeat (10) @(negedge clk);
        e0 = ev_cnt;
        exp_q.push_back(ev(1'b1, 7'd60, 7'd100));
        send_seq(0, '{8'h90, 8'h3C, 8'h64});
        chk("post_rst_count", ev_cnt - e0, 32'd1);
        chk("post_rst_queue", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
